// File: rtl/labs_energy_unit.sv
// LABS energy evaluator: accepts a +/-1 sequence and accumulates the squared
// aperiodic autocorrelation C_k^2 for k=1..N-1, one lag per clock.
module labs_energy_unit #(
  parameter int SEQ_WIDTH = 16,
  parameter int E_WIDTH   = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEQ_WIDTH-1:0] in_seq,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEQ_WIDTH-1:0] out_seq,
  output logic [E_WIDTH-1:0]   out_energy,
  output logic                 busy
);

  localparam int N       = SEQ_WIDTH;
  localparam int ACC_MAX = N * (N - 1) * (2 * N - 1) / 6;
  localparam int ACC_W   = ($clog2(ACC_MAX + 1) > 11) ? $clog2(ACC_MAX + 1) : 11;
  localparam int KW      = $clog2(N);
  localparam int CW      = KW + 2;
  localparam int SW      = (ACC_W > E_WIDTH) ? ACC_W : E_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     seq_q, seq_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;

  // Lag datapath: mismatching pairs (s_i != s_{i+k}) over the N-k overlapping positions.
  logic [N-1:0] shifted;
  logic [N-1:0] diff;
  assign shifted = seq_q >> k_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_diff
    assign diff[gi] = (seq_q[gi] ^ shifted[gi]) & ((gi + int'(k_q)) < N);
  end

  logic [KW:0]              pop;
  logic [CW-1:0]            n_minus_k;
  logic [CW-1:0]            two_pop;
  logic signed [CW-1:0]     c_k;
  logic signed [2*CW-1:0]   c_ext;
  logic [2*CW-1:0]          c_sq;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + (KW + 1)'(diff[i]);
    end
  end

  assign n_minus_k = CW'(N) - CW'(k_q);
  assign two_pop   = {pop, 1'b0};
  assign c_k       = signed'(n_minus_k - two_pop);
  assign c_ext     = (2 * CW)'(c_k);
  assign c_sq      = unsigned'(c_ext * c_ext);

  logic accept;
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    acc_d   = acc_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          seq_d   = in_seq;
          acc_d   = '0;
          k_d     = KW'(1);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_q + ACC_W'(c_sq);
        if (k_q == KW'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        // Result and a new candidate can hand over on the same edge.
        if (out_ready) begin
          if (in_valid) begin
            seq_d   = in_seq;
            acc_d   = '0;
            k_d     = KW'(1);
            state_d = S_CALC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      seq_q   <= '0;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

  logic [SW-1:0] acc_wide;
  logic [SW-1:0] e_max;
  assign acc_wide = SW'(acc_q);
  assign e_max    = SW'({E_WIDTH{1'b1}});

  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_seq    = seq_q;
  assign out_energy = (acc_wide > e_max) ? {E_WIDTH{1'b1}} : E_WIDTH'(acc_wide);

endmodule

// File: tb/tb_labs_energy_unit.sv
// Scoreboard bench for labs_energy_unit: four instances with different
// sequence/energy widths, directed cases plus random candidates.
module tb_labs_energy_unit;

  function automatic int n_of(int u);
    case (u)
      0: return 16;
      1: return 13;
      2: return 4;
      default: return 16;
    endcase
  endfunction

  function automatic int e_of(int u);
    return (u == 3) ? 10 : 16;
  endfunction

  typedef struct {
    logic [31:0] seq;
    logic [31:0] en;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        iv   [4];
  logic        ordy [4];
  logic [31:0] iseq [4];
  logic        ir   [4];
  logic        ov   [4];
  logic        bsy  [4];
  logic [31:0] oseq [4];
  logic [31:0] oen  [4];

  exp_t sbq [4][$];
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_unit
    localparam int GN = n_of(gi);
    localparam int GE = e_of(gi);
    logic [GN-1:0] os;
    logic [GE-1:0] oe;
    labs_energy_unit #(.SEQ_WIDTH(GN), .E_WIDTH(GE)) u_dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .in_valid   (iv[gi]),
      .in_ready   (ir[gi]),
      .in_seq     (iseq[gi][GN-1:0]),
      .out_valid  (ov[gi]),
      .out_ready  (ordy[gi]),
      .out_seq    (os),
      .out_energy (oe),
      .busy       (bsy[gi])
    );
    assign oseq[gi] = 32'(os);
    assign oen[gi]  = 32'(oe);
  end

  task automatic chk(input string tag, input int u, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s unit=%0d observed=%0d expected=%0d", tag, u, obs, exp);
    end
  endtask

  // Independent reference: pairwise +/-1 products summed per lag.
  function automatic int ref_energy(int n, int ew, logic [31:0] s);
    int e;
    int c;
    int emax;
    e = 0;
    for (int k = 1; k < n; k++) begin
      c = 0;
      for (int i = 0; i < n - k; i++) begin
        c += (s[i] == s[i + k]) ? 1 : -1;
      end
      e += c * c;
    end
    emax = (1 << ew) - 1;
    return (e > emax) ? emax : e;
  endfunction

  function automatic logic [31:0] mask_of(int u);
    return 32'((64'd1 << n_of(u)) - 1);
  endfunction

  // Scoreboard consumer: pops one entry per completed output handshake.
  always @(negedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (!rst && ov[u] && ordy[u]) begin
        if (sbq[u].size() == 0) begin
          total++;
          bad++;
          $error("FAIL sb_unexpected_result unit=%0d observed_seq=%0h expected=none", u, oseq[u]);
        end else begin
          exp_t e;
          e = sbq[u].pop_front();
          chk("out_seq", u, 64'(oseq[u]), 64'(e.seq));
          chk("out_energy", u, 64'(oen[u]), 64'(e.en));
        end
      end
    end
  end

  // Wait until the cycle-level latency expires or out_valid rises; returns at a negedge.
  task automatic wait_result(input int u, input int lat);
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (ov[u]) break;
      if (cyc == 1) chk("busy_in_calc", u, 64'(bsy[u]), 64'd1);
      @(posedge clk);
      cyc++;
      if (cyc > 200) break;
    end
    chk("latency", u, 64'(cyc), 64'(lat));
  endtask

  task automatic start_and_wait(input int u, input logic [31:0] s, input int exp_e);
    int guard;
    sbq[u].push_back('{seq: s, en: 32'(exp_e)});
    @(posedge clk);
    #1;
    iv[u]   = 1'b1;
    iseq[u] = s;
    guard   = 0;
    forever begin
      @(negedge clk);
      if (ir[u]) break;
      guard++;
      if (guard > 200) begin
        chk("accept_timeout", u, 64'(ir[u]), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
    wait_result(u, n_of(u) - 1);
  endtask

  task automatic run_unit(input int u, input logic [31:0] s, input int exp_e);
    start_and_wait(u, s, exp_e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] sa;
    logic [31:0] sb;
    int          ea;
    int          seen;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int u = 0; u < 4; u++) begin
      iv[u]   = 1'b0;
      ordy[u] = 1'b1;
      iseq[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      chk("rst_in_ready", u, 64'(ir[u]), 64'd1);
      chk("rst_out_valid", u, 64'(ov[u]), 64'd0);
      chk("rst_busy", u, 64'(bsy[u]), 64'd0);
      chk("rst_out_seq", u, 64'(oseq[u]), 64'd0);
      chk("rst_out_energy", u, 64'(oen[u]), 64'd0);
    end

    // Directed cases with known energies.
    run_unit(0, 32'h0000, 1240);
    run_unit(1, 32'h159F, 6);
    run_unit(2, 32'hB, 2);
    run_unit(3, 32'hAAAA, 1023);

    // Random candidates against the reference model.
    for (int r = 0; r < 4; r++) begin
      for (int u = 0; u < 4; u++) begin
        s = $urandom() & mask_of(u);
        run_unit(u, s, ref_energy(n_of(u), e_of(u), s));
      end
    end

    // Backpressure, then simultaneous output/input handshake.
    sa = $urandom() & 32'hFFFF;
    sb = ~sa & 32'hFFFF;
    ea = ref_energy(16, 16, sa);
    ordy[0] = 1'b0;
    start_and_wait(0, sa, ea);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      iv[0]   = 1'b1;
      iseq[0] = sb;
      @(negedge clk);
      chk("hold_out_valid", 0, 64'(ov[0]), 64'd1);
      chk("hold_out_seq", 0, 64'(oseq[0]), 64'(sa));
      chk("hold_out_energy", 0, 64'(oen[0]), 64'(ea));
      chk("hold_in_ready", 0, 64'(ir[0]), 64'd0);
    end
    sbq[0].push_back('{seq: sb, en: 32'(ref_energy(16, 16, sb))});
    @(posedge clk);
    #1 ordy[0] = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 0, 64'(ir[0]), 64'd1);
    @(posedge clk);
    #1 iv[0] = 1'b0;
    wait_result(0, 15);
    @(posedge clk);
    #1;

    // Reset in the middle of a calculation (k=7): result must vanish.
    @(posedge clk);
    #1;
    iv[0]   = 1'b1;
    iseq[0] = 32'h1234;
    @(negedge clk);
    chk("rst_case_in_ready", 0, 64'(ir[0]), 64'd1);
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 0, 64'(ir[0]), 64'd1);
    chk("midrst_out_valid", 0, 64'(ov[0]), 64'd0);
    chk("midrst_busy", 0, 64'(bsy[0]), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0]) seen = 1;
    end
    chk("midrst_no_result", 0, 64'(seen), 64'd0);

    for (int u = 0; u < 4; u++) begin
      chk("sb_drained", u, 64'(sbq[u].size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
